// File: rtl/mem_loader_pkg.sv
// Shared CPU parameters for the boot loader, CPU and RAM, plus a small sizing helper.
package mem_loader_pkg;

    localparam int MEM_ADDR_WIDTH = 9;   // 512-word CPU RAM
    localparam int CPU_DATA_WIDTH = 32;  // RAM word width (32 only)

    // Number of words the RAM can hold. The result is 17 bits wide so that it
    // can be compared against a full 16-bit length header without overflow.
    function automatic logic [16:0] max_words(input int aw);
        return 17'(1) << aw;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and RAM write bus of the boot loader.
// The master modport is the loader side. The slave modport is the environment
// side, which feeds bytes and consumes writes.
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = mem_loader_pkg::MEM_ADDR_WIDTH
) ();

    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_wdata;
    logic                      cpu_reset;
    logic                      done;
    logic                      error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
    );

endinterface

// File: rtl/mem_loader.sv
// Boot loader. It takes a big-endian word count N, then N big-endian 32-bit
// words, and writes them to CPU RAM from address 0 while holding the CPU in
// reset. Every output comes from a register. rx_ready is itself registered,
// so there is no combinational path from rx_valid to any output.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = mem_loader_pkg::MEM_ADDR_WIDTH,
    parameter int CPU_DATA_WIDTH = mem_loader_pkg::CPU_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mem_loader_if.master   bus
);

    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR} state_t;

    localparam logic [16:0] MAX_WORDS = max_words(MEM_ADDR_WIDTH);

    state_t                    state;
    logic [15:0]               len;
    logic [16:0]               wcnt;    // words written so far
    logic [MEM_ADDR_WIDTH-1:0] addr;    // next write address
    logic [1:0]                bcnt;    // bytes of the current word received
    logic [CPU_DATA_WIDTH-1:0] shreg;   // byte assembly shift register

    logic                      rx_ready_q, mem_we_q, cpu_reset_q, done_q, error_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [CPU_DATA_WIDTH-1:0] mem_wdata_q;

    logic                      xfer;
    logic [15:0]               len_next;
    logic [CPU_DATA_WIDTH-1:0] word_next;
    logic [16:0]               wnext;

    // Handshake and the next values of the length register and assembly register.
    always_comb begin
        xfer      = bus.rx_valid && rx_ready_q;
        len_next  = {len[15:8], bus.rx_data};
        word_next = {shreg[CPU_DATA_WIDTH-9:0], bus.rx_data};
        wnext     = wcnt + 17'd1;
    end

    // Load sequencer. Each output register is set on entry to the state that
    // owns it, so the outputs line up with the state with no extra lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LEN_HI;
            len         <= '0;
            wcnt        <= '0;
            addr        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                LEN_HI: begin
                    rx_ready_q <= 1'b1;
                    if (xfer) begin
                        len[15:8] <= bus.rx_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    rx_ready_q <= 1'b1;
                    if (xfer) begin
                        len <= len_next;
                        if (len_next == 16'd0) begin
                            state       <= DONE;
                            rx_ready_q  <= 1'b0;
                            cpu_reset_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else if ({1'b0, len_next} > MAX_WORDS) begin
                            state      <= ERROR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= DATA;
                            bcnt  <= '0;
                            addr  <= '0;
                            wcnt  <= '0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shreg <= word_next;
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            state       <= WRITE;
                            rx_ready_q  <= 1'b0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr;
                            mem_wdata_q <= word_next;
                        end
                    end
                end
                WRITE: begin
                    // addr may wrap after the last word, but a wrapped value is
                    // never written: the loader has already moved to DONE.
                    addr <= addr + 1'b1;
                    wcnt <= wnext;
                    if (wnext == {1'b0, len}) begin
                        state       <= DONE;
                        cpu_reset_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        state      <= DATA;
                        rx_ready_q <= 1'b1;
                    end
                end
                DONE, ERROR: ;  // terminal until reset
                default: state <= LEN_HI;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader. It drives byte streams and compares the
// outputs and the captured RAM writes against hand-computed values.
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [8:0]  wa[$];
    logic [31:0] wd[$];

    mem_loader_if #(.MEM_ADDR_WIDTH(9)) bus ();

    mem_loader #(.MEM_ADDR_WIDTH(9), .CPU_DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Capture every RAM write, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it is accepted. The task returns #1
    // after the transfer edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("send_timeout_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        wa.delete();
        wd.delete();
    endtask

    function automatic logic [31:0] word_of(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    initial begin
        int bad;
        logic [31:0] w;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values
        step();
        step();
        chk("rst_rx_ready",  {31'd0, bus.rx_ready},  32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        chk("rst_mem_addr",  {23'd0, bus.mem_addr},  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
        chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("rst_done",      {31'd0, bus.done},      32'd0);
        chk("rst_error",     {31'd0, bus.error},     32'd0);
        reset = 1'b0;
        step();
        chk("rx_ready_after_reset", {31'd0, bus.rx_ready}, 32'd1);
        wa.delete();
        wd.delete();

        // Two words, sent back to back
        send(8'h00); send(8'h02);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("w0_we",   {31'd0, bus.mem_we},   32'd1);
        chk("w0_addr", {23'd0, bus.mem_addr}, 32'd0);
        chk("w0_data", bus.mem_wdata,         32'hDEADBEEF);
        chk("w0_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h2A);
        chk("w1_we",   {31'd0, bus.mem_we},   32'd1);
        chk("w1_addr", {23'd0, bus.mem_addr}, 32'd1);
        chk("w1_data", bus.mem_wdata,         32'h0000002A);
        chk("w1_done_not_yet", {31'd0, bus.done}, 32'd0);
        step();
        chk("two_done",      {31'd0, bus.done},      32'd1);
        chk("two_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        chk("two_we_off",    {31'd0, bus.mem_we},    32'd0);
        chk("two_rx_ready",  {31'd0, bus.rx_ready},  32'd0);
        chk("two_nwrites",   wa.size(),              32'd2);

        // Zero-length header
        do_reset();
        send(8'h00); send(8'h00);
        chk("n0_done",      {31'd0, bus.done},      32'd1);
        chk("n0_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        chk("n0_rx_ready",  {31'd0, bus.rx_ready},  32'd0);
        step();
        chk("n0_nwrites",   wa.size(),              32'd0);

        // Length 513 is one word too many
        do_reset();
        send(8'h02); send(8'h01);
        chk("n513_error",     {31'd0, bus.error},     32'd1);
        chk("n513_rx_ready",  {31'd0, bus.rx_ready},  32'd0);
        chk("n513_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("n513_done",      {31'd0, bus.done},      32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(i);
            step();
        end
        bus.rx_valid = 1'b0;
        chk("n513_nwrites",     wa.size(),          32'd0);
        chk("n513_error_stays", {31'd0, bus.error}, 32'd1);

        // Full 512-word load with random idle gaps
        do_reset();
        send(8'h02); send(8'h00);
        chk("n512_no_error", {31'd0, bus.error}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            w = word_of(i);
            for (int b = 3; b >= 0; b--) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.rx_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                end
                send(w[b*8 +: 8]);
            end
        end
        for (int n = 0; n < 10 && bus.done !== 1'b1; n++) step();
        chk("n512_done",      {31'd0, bus.done},      32'd1);
        chk("n512_nwrites",   wa.size(),              32'd512);
        chk("n512_last_addr", {23'd0, bus.mem_addr},  32'h1FF);
        chk("n512_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        bad = 0;
        for (int i = 0; i < wa.size() && i < 512; i++)
            if (wa[i] !== 9'(i) || wd[i] !== word_of(i)) bad++;
        chk("n512_order_data_mismatches", bad, 32'd0);

        // Reset partway through word 0, then a fresh one-word stream
        do_reset();
        send(8'h00); send(8'h01); send(8'h12); send(8'h34);
        reset = 1'b1;
        step();
        chk("midrst_we",       {31'd0, bus.mem_we},   32'd0);
        chk("midrst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        reset = 1'b0;
        step();
        step();
        chk("midrst_nwrites", wa.size(), 32'd0);
        send(8'h00); send(8'h01);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        chk("fresh_we",   {31'd0, bus.mem_we},   32'd1);
        chk("fresh_addr", {23'd0, bus.mem_addr}, 32'd0);
        chk("fresh_data", bus.mem_wdata,         32'h12345678);
        step();
        chk("fresh_done",    {31'd0, bus.done}, 32'd1);
        chk("fresh_nwrites", wa.size(),         32'd1);
        chk("fresh_wdata_q", (wd.size() > 0) ? wd[0] : 32'hFFFFFFFF, 32'h12345678);

        // Bytes offered while in DONE are ignored
        for (int i = 0; i < 5; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hA0 + 8'(i);
            chk("idle_done_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
            step();
            chk("idle_done_we",   {31'd0, bus.mem_we}, 32'd0);
            chk("idle_done_done", {31'd0, bus.done},   32'd1);
        end
        bus.rx_valid = 1'b0;
        chk("idle_done_nwrites", wa.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 9, word-address width of CPU RAM (512 words).
REQ-002 Parameter CPU_DATA_WIDTH, default 32, RAM word width; fixed at 32, other values unsupported.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  incoming byte from serial front end.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready.
REQ-008 mem_we  output  1  one-cycle RAM write strobe.
REQ-009 mem_addr  output  MEM_ADDR_WIDTH  RAM word address.
REQ-010 mem_wdata  output  32  RAM write data.
REQ-011 cpu_reset  output  1  holds CPU in reset while loading.
REQ-012 done  output  1  load complete; sticky until reset.
REQ-013 error  output  1  bad length header; sticky until reset.

Function
REQ-014 Stream format: 2-byte big-endian word count N, then 4*N bytes, each word big-endian (first byte -> bits 31:24).
REQ-015 States: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR; after reset state is LEN_HI.
REQ-016 LEN_HI: on transfer latch N[15:8] -> LEN_LO.
REQ-017 LEN_LO: on transfer latch N[7:0]; N==0 -> DONE; N>2**MEM_ADDR_WIDTH -> ERROR; else -> DATA with byte counter=0, word address=0.
REQ-018 DATA: each transfer shifts byte into 32-bit assembly register; 4th byte -> WRITE.
REQ-019 WRITE: exactly one cycle; mem_we=1, mem_addr=current word address, mem_wdata=assembled word; rx_ready=0.
REQ-020 Write latency: mem_we asserted the cycle immediately after the 4th byte's transfer cycle.
REQ-021 After WRITE: address+1; if words written == N -> DONE, else -> DATA.
REQ-022 rx_ready=1 in LEN_HI, LEN_LO, DATA; 0 in WRITE, DONE, ERROR; bytes offered in DONE/ERROR are ignored, not stored.
REQ-023 Cycles with rx_valid=0 in DATA hold all state; gaps of any length are legal.
REQ-024 N==2**MEM_ADDR_WIDTH is legal; final write at address 2**MEM_ADDR_WIDTH-1; address counter never wraps into a write.
REQ-025 mem_addr, mem_wdata hold their last values outside WRITE; consumers qualify with mem_we only.
REQ-026 cpu_reset=1 in every state except DONE; deasserts the first cycle DONE is entered (cycle after final WRITE).
REQ-027 done=1 exactly when state is DONE; error=1 exactly when state is ERROR; cpu_reset stays 1 in ERROR.

Reset
REQ-028 reset has priority over all transitions, including mid-word and during WRITE; partially assembled word discarded, no write issued.
REQ-029 Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0; rx_ready rises the cycle after reset deasserts.
REQ-030 A new load requires reset; loader never re-arms on its own.

Structure
REQ-031 MEM_ADDR_WIDTH and CPU_DATA_WIDTH come from the shared CPU parameter header also used by cpu and ram; state encodings are local to mem_loader.
REQ-032 Single module, no sub-modules; byte packing is a shift register inside mem_loader.
REQ-033 Outputs driven from registers; no combinational path rx_valid -> mem_we.

Verification
REQ-034 Stream 00 02 | DE AD BE EF | 00 00 00 2A, back-to-back -> writes (0,DEADBEEF),(1,0000002A); mem_we cycle after bytes 6 and 10; done and cpu_reset=0 cycle after second write.
REQ-035 Header 00 00 -> done=1, cpu_reset=0 cycle after second header byte; no mem_we ever.
REQ-036 Header 02 01 (513) -> error=1, rx_ready=0, cpu_reset stays 1, no mem_we for 20 further offered bytes.
REQ-037 N=512, random rx_valid gaps -> 512 writes, addresses 0..511 in order, data matches stream, final address 1FF, then done.
REQ-038 Reset asserted after 2 data bytes of word 0 -> no mem_we; fresh stream 00 01 | 12 34 56 78 -> single write (0,12345678).
REQ-039 Bytes offered in DONE -> rx_ready=0, no mem_we, done stays 1.
